// File: rtl/echo_pkg.sv
// Shared types and constants for the echo delay-line sequencer.
package echo_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 9;
  localparam int DELAY_MIN  = 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE
  } state_t;

endpackage

// File: rtl/delay_glide.sv
// Registered slew limiter: moves cur toward max(target, DELAY_MIN) by at most STEP per enable.
module delay_glide
  import echo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] cur
);

  localparam logic [ADDR_W-1:0] MIN_D  = ADDR_W'(DELAY_MIN);
  localparam logic [ADDR_W-1:0] STEP_D = ADDR_W'(STEP);

  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] nxt;

  always_comb begin
    tgt = (target < MIN_D) ? MIN_D : target;
    nxt = tgt;
    if (tgt > cur) begin
      if ((tgt - cur) > STEP_D) nxt = cur + STEP_D;
    end else if ((cur - tgt) > STEP_D) begin
      nxt = cur - STEP_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= MIN_D;
    else if (en) cur <= nxt;
  end

endmodule

// File: rtl/echo_delay_ctrl.sv
// Echo delay-line RAM sequencer: zero-fill after reset, then one read and one write per sample.
module echo_delay_ctrl
  import echo_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RAM_LAT  = 2,
  parameter int CALC_LAT = 1,
  parameter int STEP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_strobe,
  input  logic [ADDR_W-1:0] delay_target,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] ram_rdaddr,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  output logic              q_valid,
  output logic              busy,
  output logic              init_done,
  output logic              overrun,
  output logic [ADDR_W-1:0] delay_cur
);

  localparam int TXN_LEN = RAM_LAT + CALC_LAT;
  localparam int CNT_W   = $clog2(TXN_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_QV   = CNT_W'(RAM_LAT);
  localparam logic [CNT_W-1:0]  CNT_WR   = CNT_W'(TXN_LEN);
  localparam logic [ADDR_W:0]   FILL_END = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nx;
  logic [ADDR_W:0]   fill_cnt, fill_nx;
  logic [ADDR_W-1:0] wp, wp_nx;
  logic [CNT_W-1:0]  tcnt, tcnt_nx;
  logic [ADDR_W-1:0] rdaddr_nx, wraddr_nx;
  logic              rden_nx, wren_nx, qv_nx, busy_nx, done_nx, overrun_nx;

  // Next state plus the values every registered output takes in that next state.
  always_comb begin
    state_nx   = state;
    fill_nx    = fill_cnt;
    wp_nx      = wp;
    tcnt_nx    = tcnt;
    rdaddr_nx  = ram_rdaddr;
    wraddr_nx  = ram_wraddr;
    rden_nx    = 1'b0;
    wren_nx    = 1'b0;
    qv_nx      = 1'b0;
    done_nx    = init_done;
    overrun_nx = overrun;
    case (state)
      S_INIT: begin
        if (fill_cnt == FILL_END) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else begin
          wren_nx   = 1'b1;
          wraddr_nx = fill_cnt[ADDR_W-1:0];
          fill_nx   = fill_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (sample_strobe) begin
          state_nx  = S_READ;
          rden_nx   = 1'b1;
          rdaddr_nx = wp - delay_cur;
          tcnt_nx   = '0;
        end
      end
      S_READ, S_WAIT: begin
        tcnt_nx = tcnt + 1'b1;
        qv_nx   = (tcnt_nx == CNT_QV);
        if (tcnt_nx == CNT_WR) begin
          state_nx  = S_WRITE;
          wren_nx   = 1'b1;
          wraddr_nx = wp;
        end else begin
          state_nx = S_WAIT;
        end
        if (sample_strobe) overrun_nx = 1'b1;
      end
      S_WRITE: begin
        state_nx = S_IDLE;
        wp_nx    = wp + 1'b1;
        if (sample_strobe) overrun_nx = 1'b1;
      end
      default: state_nx = S_INIT;
    endcase
    busy_nx = (state_nx == S_READ) || (state_nx == S_WAIT) || (state_nx == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      fill_cnt   <= '0;
      wp         <= '0;
      tcnt       <= '0;
      ram_rdaddr <= '0;
      ram_wraddr <= '0;
      ram_rden   <= 1'b0;
      ram_wren   <= 1'b0;
      q_valid    <= 1'b0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      fill_cnt   <= fill_nx;
      wp         <= wp_nx;
      tcnt       <= tcnt_nx;
      ram_rdaddr <= rdaddr_nx;
      ram_wraddr <= wraddr_nx;
      ram_rden   <= rden_nx;
      ram_wren   <= wren_nx;
      q_valid    <= qv_nx;
      busy       <= busy_nx;
      init_done  <= done_nx;
      overrun    <= overrun_nx;
    end
  end

  // wr_data only settles in the WRITE cycle itself, so data is a flop-selected mux, not a flop.
  assign ram_data = (state == S_INIT) ? '0 : wr_data;

  delay_glide #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP)
  ) u_glide (
    .clk    (clk),
    .rst    (rst),
    .en     (state == S_WRITE),
    .target (delay_target),
    .cur    (delay_cur)
  );

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Self-checking bench for echo_delay_ctrl against an arithmetic model of pointer, delay glide and overrun.
module tb_echo_delay_ctrl;

  localparam int AW      = 13;
  localparam int DW      = 9;
  localparam int RL      = 2;
  localparam int CL      = 1;
  localparam int STEP_P  = 1;
  localparam int DEPTH   = 1 << AW;
  localparam int READ_C  = 1;
  localparam int QV_C    = 1 + RL;
  localparam int WRITE_C = 1 + RL + CL;
  localparam int IDLE_C  = 2 + RL + CL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_strobe = 1'b0;
  logic [AW-1:0] delay_target = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] ram_rdaddr, ram_wraddr, delay_cur;
  logic          ram_rden, ram_wren, q_valid, busy, init_done, overrun;
  logic [DW-1:0] ram_data;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_wp, m_delay, m_rdaddr, m_wraddr;
  logic m_overrun;

  echo_delay_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(RL), .CALC_LAT(CL), .STEP(STEP_P)
  ) dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe), .delay_target(delay_target),
    .wr_data(wr_data), .ram_rdaddr(ram_rdaddr), .ram_rden(ram_rden),
    .ram_wraddr(ram_wraddr), .ram_wren(ram_wren), .ram_data(ram_data),
    .q_valid(q_valid), .busy(busy), .init_done(init_done), .overrun(overrun),
    .delay_cur(delay_cur)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int glide(input int d, input int target);
    int t;
    t = (target < 1) ? 1 : target;
    if (t > d) return (t - d <= STEP_P) ? t : d + STEP_P;
    return (d - t <= STEP_P) ? t : d - STEP_P;
  endfunction

  task automatic model_reset();
    m_wp      = 0;
    m_delay   = 1;
    m_rdaddr  = 0;
    m_wraddr  = DEPTH - 1;
    m_overrun = 1'b0;
  endtask

  task automatic test_reset();
    logic [4+3*AW-1:0] got;
    rst = 1'b1;
    wr_data = DW'($urandom);
    step();
    step();
    #1;
    got = {ram_rden, ram_wren, q_valid, busy, ram_rdaddr, ram_wraddr, delay_cur};
    n_cmp++;
    if (got !== {4'b0, AW'(0), AW'(0), AW'(1)}) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs got=%h exp=%h", got, {4'b0, AW'(0), AW'(0), AW'(1)});
    end
    n_cmp++;
    if ({init_done, overrun, ram_data} !== {2'b0, DW'(0)}) begin
      n_fail++;
      $display("[TB] FAIL reset_flags got=%h exp=0", {init_done, overrun, ram_data});
    end
    // Partial zero-fill, then a reset mid-INIT must restart from address 0.
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      sample_strobe = 1'(($urandom & 1));
      step();
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({ram_wren, ram_wraddr, init_done} !== {1'b0, AW'(0), 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_init got=%h exp=0", {ram_wren, ram_wraddr, init_done});
    end
    sample_strobe = 1'b0;
  endtask

  task automatic test_init();
    logic [3+AW+DW+4-1:0] got, exp;
    rst = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      step();
      sample_strobe = (c == DEPTH - 1) ? 1'b1 : 1'(($urandom & 1));
      wr_data = DW'($urandom);
      #1;
      got = {ram_wren, ram_rden, q_valid, ram_wraddr, ram_data, init_done, busy, overrun, 1'b0};
      exp = {1'b1, 1'b0, 1'b0, AW'(c), DW'(0), 1'b0, 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("[TB] FAIL init_cycle c=%0d got=%h exp=%h", c, got, exp);
      end
    end
    step();
    sample_strobe = 1'b0;
    got = {ram_wren, ram_rden, q_valid, ram_wraddr, DW'(0), init_done, busy, overrun, 1'b0};
    exp = {1'b0, 1'b0, 1'b0, AW'(DEPTH - 1), DW'(0), 1'b1, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL init_done_edge got=%h exp=%h", got, exp);
    end
    step();
    n_cmp++;
    if ({busy, ram_rden, overrun} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL init_strobe_ignored got=%b exp=000", {busy, ram_rden, overrun});
    end
    model_reset();
  endtask

  // One sample transaction; ovr_cyc in 1..WRITE_C injects a strobe in that busy cycle.
  task automatic do_sample(input int target, input int gap, input int ovr_cyc);
    logic [6+3*AW-1:0] got, exp;
    int   exp_rd;
    logic pend;
    pend = 1'b0;
    delay_target = AW'(target);
    for (int g = 0; g < gap; g++) step();
    sample_strobe = 1'b1;
    exp_rd = (m_wp - m_delay + DEPTH) % DEPTH;
    for (int c = 1; c <= IDLE_C; c++) begin
      step();
      if (pend) m_overrun = 1'b1;
      pend = 1'b0;
      wr_data = DW'($urandom);
      sample_strobe = (c == ovr_cyc);
      if (c == ovr_cyc) pend = 1'b1;
      if (c == READ_C) m_rdaddr = exp_rd;
      if (c == WRITE_C) m_wraddr = m_wp;
      if (c == IDLE_C) begin
        m_wp    = (m_wp + 1) % DEPTH;
        m_delay = glide(m_delay, target);
      end
      #1;
      got = {ram_rden, ram_wren, q_valid, busy, overrun, init_done, ram_rdaddr, ram_wraddr, delay_cur};
      exp = {(c == READ_C), (c == WRITE_C), (c == QV_C), (c < IDLE_C), m_overrun, 1'b1,
             AW'(m_rdaddr), AW'(m_wraddr), AW'(m_delay)};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("[TB] FAIL txn wp=%0d c=%0d got=%h exp=%h", m_wp, c, got, exp);
      end
      if (c == WRITE_C) begin
        n_cmp++;
        if (ram_data !== wr_data) begin
          n_fail++;
          $display("[TB] FAIL write_data got=%h exp=%h", ram_data, wr_data);
        end
      end
    end
    sample_strobe = 1'b0;
  endtask

  task automatic test_glide();
    for (int i = 0; i < 5; i++) do_sample(5, 1, 0);
    for (int i = 0; i < 6; i++) do_sample(0, 0, 0);
  endtask

  task automatic test_overrun();
    do_sample(3, 2, 2);
    do_sample(3, 0, 0);
    do_sample(4, 1, WRITE_C);
    do_sample(4, 0, READ_C);
  endtask

  task automatic test_back_to_back();
    while (m_wp != 100) do_sample(8, 0, 0);
    do_sample(8, 0, 0);
  endtask

  task automatic test_wrap();
    while (m_wp != DEPTH - 40)
      do_sample($urandom_range(0, 30), $urandom_range(0, 1),
                ($urandom_range(0, 31) == 0) ? $urandom_range(1, WRITE_C) : 0);
    do begin
      do_sample(10, 0, 0);
    end while (m_wp != 4);
  endtask

  task automatic test_reset_wait();
    delay_target = AW'(20);
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    step();
    n_cmp++;
    if ({busy, ram_wren} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL rst_wait_pre got=%b exp=10", {busy, ram_wren});
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({ram_wren, ram_wraddr, delay_cur, overrun, busy, init_done, q_valid} !==
        {1'b0, AW'(0), AW'(1), 4'b0000}) begin
      n_fail++;
      $display("[TB] FAIL rst_wait_state got=%h exp=%h",
               {ram_wren, ram_wraddr, delay_cur, overrun, busy, init_done, q_valid},
               {1'b0, AW'(0), AW'(1), 4'b0000});
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, AW'(c), DW'(0)}) begin
        n_fail++;
        $display("[TB] FAIL rst_wait_refill c=%0d got=%h exp=%h", c,
                 {ram_wren, ram_wraddr, ram_data}, {1'b1, AW'(c), DW'(0)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_glide();
    test_overrun();
    test_back_to_back();
    test_wrap();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
